// File: rtl/alu_seq_if.sv
// Operand/op handshake and registered result/flag bus of the sequential ALU.
// The master drives operands; the slave (the ALU) returns result, flags and status.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             inValid;
  logic             inReady;
  logic [3:0]       aluControl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             outValid;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             C, L, F, Z, N;

  modport master (
    output inValid, aluControl, a, b,
    input  inReady, outValid, result, busy, C, L, F, Z, N
  );

  modport slave (
    input  inValid, aluControl, a, b,
    output inReady, outValid, result, busy, C, L, F, Z, N
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops with persistent C,L,F,Z,N flags,
// plus an iterative shift-add multiply that holds off new ops while it runs.
module alu_seq #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input logic      clk,
  input logic      reset_n,
  alu_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int M  = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_CMP  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_MOV  = 4'b0110;
  localparam logic [3:0] OP_LSH  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_ADDC = 4'b1001;
  localparam logic [3:0] OP_SUBC = 4'b1010;

  localparam logic [WIDTH-1:0] WLIM = WIDTH[WIDTH-1:0];

  typedef enum logic {IDLE, MUL} state_t;

  typedef struct packed {
    logic c;
    logic l;
    logic f;
    logic z;
    logic n;
  } flags_t;

  state_t             state_q;
  logic [WIDTH-1:0]   result_q;
  flags_t             flg_q;
  logic               outValid_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;

  logic               accept;
  logic               is_mul;
  logic               cin;
  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     sub_w;
  logic [WIDTH-1:0]   neg_b;
  logic [WIDTH-1:0]   sh_res;
  logic [WIDTH-1:0]   res_d;
  flags_t             flg_d;
  logic               zn;
  logic [2*WIDTH-1:0] acc_nx;

  assign accept = bus.inValid && (state_q == IDLE);
  assign is_mul = MUL_EN && (bus.aluControl == OP_MUL);

  // Carry-in is the flag as registered before this op, so chained ADDC/SUBC
  // see the C written by the op accepted on the previous edge.
  assign cin   = ((bus.aluControl == OP_ADDC) || (bus.aluControl == OP_SUBC)) ? flg_q.c : 1'b0;
  assign add_w = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, cin};
  assign sub_w = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, cin};

  // b is a signed shift distance; negative shifts right logically.
  assign neg_b  = -bus.b;
  assign sh_res = bus.b[M] ? ((neg_b >= WLIM) ? '0 : (bus.a >> neg_b))
                           : ((bus.b >= WLIM) ? '0 : (bus.a << bus.b));

  always_comb begin
    res_d = result_q;
    flg_d = flg_q;
    zn    = 1'b0;
    case (bus.aluControl)
      OP_ADD, OP_ADDC: begin
        res_d   = add_w[WIDTH-1:0];
        flg_d.c = add_w[WIDTH];
        flg_d.f = (bus.a[M] == bus.b[M]) && (add_w[M] != bus.a[M]);
        zn      = 1'b1;
      end
      OP_SUB, OP_SUBC: begin
        res_d   = sub_w[WIDTH-1:0];
        flg_d.c = sub_w[WIDTH];
        flg_d.f = (bus.a[M] != bus.b[M]) && (sub_w[M] != bus.a[M]);
        zn      = 1'b1;
      end
      OP_CMP: begin
        flg_d.c = sub_w[WIDTH];
        flg_d.f = (bus.a[M] != bus.b[M]) && (sub_w[M] != bus.a[M]);
        flg_d.z = (bus.a == bus.b);
        flg_d.l = (bus.a < bus.b);
        flg_d.n = ($signed(bus.a) < $signed(bus.b));
      end
      OP_AND: begin res_d = bus.a & bus.b; zn = 1'b1; end
      OP_OR:  begin res_d = bus.a | bus.b; zn = 1'b1; end
      OP_XOR: begin res_d = bus.a ^ bus.b; zn = 1'b1; end
      OP_MOV: begin res_d = bus.b;         zn = 1'b1; end
      OP_LSH: begin res_d = sh_res;        zn = 1'b1; end
      default: ;
    endcase
    if (zn) begin
      flg_d.z = ~|res_d;
      flg_d.n = res_d[M];
    end
  end

  assign acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);

  // One multiplier bit per MUL cycle; the final partial sum is written
  // straight to result on the edge where the counter hits zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      result_q   <= '0;
      flg_q      <= '0;
      outValid_q <= 1'b0;
      mcand_q    <= '0;
      acc_q      <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
    end else begin
      outValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              mcand_q  <= {{WIDTH{1'b0}}, bus.a};
              mplier_q <= bus.b;
              acc_q    <= '0;
              cnt_q    <= CW'(WIDTH);
              state_q  <= MUL;
            end else begin
              result_q   <= res_d;
              flg_q      <= flg_d;
              outValid_q <= 1'b1;
            end
          end
        end
        MUL: begin
          acc_q    <= acc_nx;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_q   <= acc_nx[WIDTH-1:0];
            flg_q.z    <= ~|acc_nx[WIDTH-1:0];
            flg_q.c    <= |acc_nx[2*WIDTH-1:WIDTH];
            outValid_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.inReady  = (state_q == IDLE);
  assign bus.busy     = (state_q == MUL);
  assign bus.outValid = outValid_q;
  assign bus.result   = result_q;
  assign bus.C        = flg_q.c;
  assign bus.L        = flg_q.l;
  assign bus.F        = flg_q.f;
  assign bus.Z        = flg_q.z;
  assign bus.N        = flg_q.n;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=16): vector table plus hand sequences for MUL and reset,
// with an outValid-driven scoreboard checking result, flags and arrival cycle.
module tb_alu_seq;

  localparam int W = 16;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [4:0]   flg;   // {C,L,F,Z,N}
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic [4:0]   flg;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sbq[$];
  vec_t tbl[20];

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4:0] flags();
    return {bus.C, bus.L, bus.F, bus.Z, bus.N};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every outValid pulse must match the oldest pending op.
  always @(negedge clk) begin
    if (reset_n && bus.outValid) begin
      n_vec++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_outValid at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (bus.result !== e.res || flags() !== e.flg || cyc != e.cyc) begin
          n_err++;
          $display("FAIL result: got res=%h flg=%b cyc=%0d expected res=%h flg=%b cyc=%0d",
                   bus.result, flags(), cyc, e.res, e.flg, e.cyc);
        end
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] er, input logic [4:0] ef, input int lat);
    int t;
    t = 0;
    while (!bus.inReady && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.inReady) begin
      n_vec++;
      n_err++;
      $display("FAIL send_ready_timeout: inReady %b expected 1", bus.inReady);
      return;
    end
    bus.inValid    = 1'b1;
    bus.aluControl = op;
    bus.a          = a;
    bus.b          = b;
    sbq.push_back('{er, ef, cyc + 1 + lat});
    @(posedge clk);
    #1;
    bus.inValid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("drain_pending", sbq.size(), 0);
    sbq.delete();
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_result"},   bus.result, 16'h0000);
    check({name, "_flags"},    flags(), 5'b00000);
    check({name, "_inReady"},  bus.inReady, 1'b1);
    check({name, "_outValid"}, bus.outValid, 1'b0);
    check({name, "_busy"},     bus.busy, 1'b0);
  endtask

  initial begin
    int n;
    bus.inValid    = 1'b0;
    bus.aluControl = 4'h0;
    bus.a          = '0;
    bus.b          = '0;

    //            op     a         b         result    {C,L,F,Z,N}
    tbl[0]  = '{4'h0, 16'hFFFF, 16'h0001, 16'h0000, 5'b10010};  // ADD carry out, zero
    tbl[1]  = '{4'h9, 16'h0000, 16'h0000, 16'h0001, 5'b00000};  // ADDC uses C from previous op
    tbl[2]  = '{4'h1, 16'h0001, 16'h0002, 16'hFFFF, 5'b10001};  // SUB borrow
    tbl[3]  = '{4'h1, 16'h8000, 16'h0001, 16'h7FFF, 5'b00100};  // SUB signed overflow
    tbl[4]  = '{4'h2, 16'h0002, 16'h0003, 16'h7FFF, 5'b11001};  // CMP less-than, result kept
    tbl[5]  = '{4'h2, 16'hFFFF, 16'h0001, 16'h7FFF, 5'b00001};  // CMP signed vs unsigned
    tbl[6]  = '{4'h3, 16'hF0F0, 16'h0FF0, 16'h00F0, 5'b00000};  // AND
    tbl[7]  = '{4'h4, 16'h8000, 16'h0001, 16'h8001, 5'b00001};  // OR
    tbl[8]  = '{4'h5, 16'hAAAA, 16'hAAAA, 16'h0000, 5'b00010};  // XOR
    tbl[9]  = '{4'h6, 16'h5555, 16'h1234, 16'h1234, 5'b00000};  // MOV
    tbl[10] = '{4'h7, 16'h0081, 16'hFFFC, 16'h0008, 5'b00000};  // LSH right by 4
    tbl[11] = '{4'h7, 16'h0081, 16'h0010, 16'h0000, 5'b00010};  // LSH by WIDTH -> 0
    tbl[12] = '{4'h7, 16'h0081, 16'h0004, 16'h0810, 5'b00000};  // LSH left by 4
    tbl[13] = '{4'h1, 16'h0000, 16'h0001, 16'hFFFF, 5'b10001};  // SUB sets C
    tbl[14] = '{4'hA, 16'h0000, 16'h0000, 16'hFFFF, 5'b10001};  // SUBC with C=1
    tbl[15] = '{4'hF, 16'h1111, 16'h2222, 16'hFFFF, 5'b10001};  // no-op
    tbl[16] = '{4'hB, 16'h3333, 16'h4444, 16'hFFFF, 5'b10001};  // no-op
    tbl[17] = '{4'h9, 16'h0001, 16'h0001, 16'h0003, 5'b00000};  // ADDC with C=1
    tbl[18] = '{4'h0, 16'h7FFF, 16'h0001, 16'h8000, 5'b00101};  // ADD signed overflow
    tbl[19] = '{4'h7, 16'h1234, 16'h8000, 16'h0000, 5'b00110};  // LSH most-negative -> 0, F holds

    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset_init");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Back-to-back single-cycle ops
    foreach (tbl[i]) send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].flg, 0);
    drain();

    // MUL: inReady low for WIDTH cycles; L, F, N hold
    send(4'h8, 16'h0123, 16'h0045, 16'h4E6F, 5'b00100, W);
    check("mul_busy", bus.busy, 1'b1);
    n = 0;
    while (!bus.inReady && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("mul_inReady_low_cycles", n, W);
    send(4'h8, 16'hFFFF, 16'h0002, 16'hFFFE, 5'b10100, W);
    drain();

    // Reset lands while outValid is high after a SUB
    send(4'h1, 16'h0001, 16'h0002, 16'hFFFF, 5'b10001, 0);
    check("pre_reset_outValid", bus.outValid, 1'b1);
    reset_n = 1'b0;
    sbq.delete();
    #1;
    check_reset_state("reset_mid");
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a MUL discards it entirely
    send(4'h8, 16'h0123, 16'h0045, 16'h4E6F, 5'b00000, W);
    repeat (4) @(posedge clk);
    #1;
    check("mul_busy_before_reset", bus.busy, 1'b1);
    reset_n = 1'b0;
    sbq.delete();
    #1;
    check_reset_state("reset_mul");
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    repeat (W + 4) @(posedge clk);
    @(negedge clk);

    send(4'h0, 16'h0002, 16'h0003, 16'h0005, 5'b00000, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: time %0t limit 200000", $time);
    $fatal(1);
  end

endmodule
